// File: rtl/l2_request_buffer.sv
// l2_request_buffer: per-core in-order request FIFOs feeding the L2 request ports.
// Optional feature macro: L2_REQ_BUFFER_BYPASS_EN (zero-latency bypass on an empty FIFO).
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_request_buffer_pkg;
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [5:0]  tag;
    } l2req_packet_t;
endpackage

module l2_request_buffer
    import l2_request_buffer_pkg::*;
#(
    parameter int NUM_PORTS  = `NUM_CORES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          l1_request_valid,
    input  l2req_packet_t [NUM_PORTS-1:0] l1_request,
    output logic [NUM_PORTS-1:0]          l1_ready,
    output logic [NUM_PORTS-1:0]          l2i_request_valid,
    output l2req_packet_t [NUM_PORTS-1:0] l2i_request,
    input  logic [NUM_PORTS-1:0]          l2_ready,
    output logic [NUM_PORTS-1:0]          rb_full_event
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    assign rb_full_event = l1_request_valid & ~l1_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_core
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] count;
        logic [CW-1:0] count_next;
        logic          ready_q;
        logic          empty;
        logic          push;
        logic          wr_en;
        logic          rd_en;
        l2req_packet_t mem [FIFO_DEPTH];

        assign empty = (count == '0);
        assign push  = l1_request_valid[i] & ready_q;
        assign l1_ready[i] = ready_q;

`ifdef L2_REQ_BUFFER_BYPASS_EN
        // An empty FIFO forwards the offer; it is stored only if L2 refuses it.
        assign l2i_request_valid[i] = !empty || push;
        assign l2i_request[i]       = empty ? l1_request[i] : mem[rd_ptr];
        assign wr_en = push && !(empty && l2_ready[i]);
        assign rd_en = !empty && l2_ready[i];
`else
        assign l2i_request_valid[i] = !empty;
        assign l2i_request[i]       = mem[rd_ptr];
        assign wr_en = push;
        assign rd_en = !empty && l2_ready[i];
`endif

        always_comb begin
            count_next = count;
            unique case ({wr_en, rd_en})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                ready_q <= 1'b1;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                count   <= count_next;
                ready_q <= (count_next < DEPTH);
            end
        end

        // Payload storage is intentionally not reset.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= l1_request[i];
        end
    end

endmodule

// File: tb/tb_l2_request_buffer.sv
// tb_l2_request_buffer: table-driven vectors plus per-core scoreboard.
// Expected latencies adapt to L2_REQ_BUFFER_BYPASS_EN when defined.
module tb_l2_request_buffer;
    import l2_request_buffer_pkg::*;

    localparam int NP = 4;
`ifdef L2_REQ_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NP-1:0]          l1_request_valid = '0;
    l2req_packet_t [NP-1:0] l1_request = '0;
    logic [NP-1:0]          l1_ready;
    logic [NP-1:0]          l2i_request_valid;
    l2req_packet_t [NP-1:0] l2i_request;
    logic [NP-1:0]          l2_ready = '0;
    logic [NP-1:0]          rb_full_event;

    int checks = 0;
    int passed = 0;
    logic [31:0] sbq [NP][$];

    l2_request_buffer #(.NUM_PORTS(NP), .FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .l1_request_valid  (l1_request_valid),
        .l1_request        (l1_request),
        .l1_ready          (l1_ready),
        .l2i_request_valid (l2i_request_valid),
        .l2i_request       (l2i_request),
        .l2_ready          (l2_ready),
        .rb_full_event     (rb_full_event)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NP-1:0] v, input logic [31:0] a,
                         input logic [NP-1:0] r);
        l1_request_valid = v;
        l2_ready = r;
        for (int i = 0; i < NP; i++) begin
            l1_request[i].op   = 2'b00;
            l1_request[i].addr = a;
            l1_request[i].tag  = 6'(i);
        end
    endtask

    task automatic drain(input logic [NP-1:0] mask);
        int n;
        n = 0;
        l1_request_valid = '0;
        l2_ready = mask;
        @(negedge clk);
        while (((l2i_request_valid & mask) != '0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 30), 32'd1);
    endtask

    // Scoreboard: record accepted pushes, compare every accepted pop.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                if (l1_request_valid[i] && l1_ready[i])
                    sbq[i].push_back(l1_request[i].addr);
                if (l2i_request_valid[i] && l2_ready[i]) begin
                    if (sbq[i].size() == 0)
                        check($sformatf("sb_extra_core%0d", i),
                              l2i_request[i].addr, 32'hdead_beef);
                    else
                        check($sformatf("sb_order_core%0d", i),
                              l2i_request[i].addr, sbq[i].pop_front());
                end
            end
        end
    end

    typedef struct {
        string         name;
        logic [NP-1:0] v;
        logic [31:0]   a;
        logic [NP-1:0] r;
        logic [NP-1:0] rdy;
        logic [NP-1:0] vld;
        logic [NP-1:0] full;
    } vec_t;

    vec_t vt [13];

    initial begin : main
        int n;
        vt[0]  = '{"push_a",   4'h1, 32'h1000, 4'h1, 4'hF, BYP ? 4'h1 : 4'h0, 4'h0};
        vt[1]  = '{"show_a",   4'h0, 32'h0,    4'h1, 4'hF, BYP ? 4'h0 : 4'h1, 4'h0};
        vt[2]  = '{"idle",     4'h0, 32'h0,    4'h0, 4'hF, 4'h0, 4'h0};
        vt[3]  = '{"fill0",    4'h1, 32'h100,  4'h0, 4'hF, BYP ? 4'h1 : 4'h0, 4'h0};
        vt[4]  = '{"fill1",    4'h1, 32'h140,  4'h0, 4'hF, 4'h1, 4'h0};
        vt[5]  = '{"fill2",    4'h1, 32'h180,  4'h0, 4'hF, 4'h1, 4'h0};
        vt[6]  = '{"fill3",    4'h1, 32'h1c0,  4'h0, 4'hF, 4'h1, 4'h0};
        vt[7]  = '{"offer5",   4'h1, 32'h200,  4'h0, 4'hE, 4'h1, 4'h1};
        vt[8]  = '{"pop1",     4'h0, 32'h0,    4'h1, 4'hE, 4'h1, 4'h0};
        vt[9]  = '{"pop2",     4'h0, 32'h0,    4'h1, 4'hF, 4'h1, 4'h0};
        vt[10] = '{"pop3",     4'h0, 32'h0,    4'h1, 4'hF, 4'h1, 4'h0};
        vt[11] = '{"pop4",     4'h0, 32'h0,    4'h1, 4'hF, 4'h1, 4'h0};
        vt[12] = '{"empty",    4'h0, 32'h0,    4'h0, 4'hF, 4'h0, 4'h0};

        drive('0, 32'h0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(l2i_request_valid), 32'h0);
        check("rst_ready", 32'(l1_ready), 32'hF);
        check("rst_full",  32'(rb_full_event), 32'h0);
        cyc();
        reset = 1'b1;

        for (int k = 0; k < 13; k++) begin
            cyc();
            drive(vt[k].v, vt[k].a, vt[k].r);
            @(negedge clk);
            check({vt[k].name, "_rdy"},  32'(l1_ready), 32'(vt[k].rdy));
            check({vt[k].name, "_vld"},  32'(l2i_request_valid), 32'(vt[k].vld));
            check({vt[k].name, "_full"}, 32'(rb_full_event), 32'(vt[k].full));
        end
        check("core0_sb_empty", 32'(sbq[0].size()), 32'd0);

        // Core1 streaming push+pop at occupancy one.
        cyc();
        drive(4'h2, 32'h300, 4'h0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            drive(4'h2, 32'h340 + 32'(k) * 32'h40, 4'h2);
            @(negedge clk);
            check($sformatf("stream%0d_vld1", k), 32'(l2i_request_valid[1]), 32'd1);
            check($sformatf("stream%0d_rdy1", k), 32'(l1_ready[1]), 32'd1);
            check($sformatf("stream%0d_core0", k), 32'(l2i_request_valid[0]), 32'd0);
        end
        cyc();
        drain(4'h2);
        check("core1_sb_empty", 32'(sbq[1].size()), 32'd0);

        // Async reset with three entries queued on core2.
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive(4'h4, 32'h4000 + 32'(k) * 32'h10, 4'h0);
        end
        cyc();
        drive('0, 32'h0, '0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_vld", 32'(l2i_request_valid), 32'h0);
        check("async_rst_rdy", 32'(l1_ready), 32'hF);
        for (int i = 0; i < NP; i++) sbq[i].delete();
        cyc();
        reset = 1'b1;
        cyc();
        drive(4'h4, 32'h5000, 4'h0);
        n = 0;
        @(negedge clk);
        while (!l2i_request_valid[2] && n < 5) begin
            @(negedge clk);
            n++;
            l1_request_valid = '0;
        end
        check("post_rst_first", l2i_request[2].addr, 32'h5000);
        cyc();
        drain(4'h4);
        check("core2_sb_empty", 32'(sbq[2].size()), 32'd0);

        // All cores push together with mixed L2 back-pressure.
        for (int c = 0; c < 3; c++) begin
            cyc();
            drive(4'hF, 32'h0, 4'($urandom_range(0, 15)));
            for (int i = 0; i < NP; i++)
                l1_request[i].addr = 32'h8000 + 32'(i) * 32'h100 + 32'(c) * 32'h10;
        end
        for (int c = 0; c < 6; c++) begin
            cyc();
            drive('0, 32'h0, 4'($urandom_range(0, 15)));
        end
        cyc();
        drain(4'hF);
        for (int i = 0; i < NP; i++)
            check($sformatf("mix_sb_empty%0d", i), 32'(sbq[i].size()), 32'd0);
        check("mix_vld_final", 32'(l2i_request_valid), 32'h0);

        cyc();
        drive('0, 32'h0, '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
